dds_fword_ctrl: RTL
===================

Name: dds_fword_ctrl

Overview:
- Command controller between the SPI slave byte interface and the DDS phase accumulator.
- Decodes framed SPI commands and assembles the 32-bit frequency word into a shadow register.
- Commits the shadow word to the DDS only on a phase-accumulator wrap, so frequency changes are glitch-free, with a timeout fallback.
- Also drives the DDS enable and returns a status byte to the SPI master.

Parameters:
- RESET_FWORD, 32'd0, fword_out value after reset.
- TIMEOUT_W, 16, width of the commit-timeout counter.
- COMMIT_TIMEOUT, 16'd50000, clk cycles a pending commit waits for phase_wrap before forcing the load.

Ports:
- clk, input, 1, DDS clock; all logic runs on its rising edge.
- rst, input, 1, reset, asynchronous, active-low.
- cs_n, input, 1, SPI chip select, asynchronous; 2-FF synchronised internally; high = frame end.
- rx_byte, input, 8, received SPI byte; valid only while rx_valid = 1.
- rx_valid, input, 1, one-cycle pulse in the clk domain per received byte.
- tx_byte, output, 8, status byte for the SPI slave to shift out next.
- phase_wrap, input, 1, one-cycle pulse on DDS accumulator overflow.
- fword_out, output, 32, frequency word to the DDS.
- fword_load, output, 1, one-cycle pulse in the cycle fword_out changes.
- dds_en, output, 1, DDS output enable.
- pending, output, 1, commit armed and not yet applied.
- err, output, 1, sticky protocol error.

Behaviour:
- Reset values: fword_out = RESET_FWORD; shadow = RESET_FWORD; fword_load = 0; dds_en = 0; pending = 0; err = 0; tx_byte = 8'h00; frame FSM = IDLE; timeout counter = 0.
- Frame FSM states:
  - IDLE: on synchronised cs_n falling edge -> OPCODE.
  - OPCODE: next rx_valid byte is the opcode.
  - DATA: collects data bytes.
  - DISCARD: ignores bytes until frame end.
- In any state, synchronised cs_n high -> IDLE. The partial assembly is dropped; shadow is unchanged.
- Opcodes:
  - 0x01 WRITE_FWORD: 4 data bytes, MSB first, shifted into an assembly register. On the 4th byte: shadow <= assembly in the next cycle -> DISCARD.
  - 0x02 COMMIT: no data. pending <= 1; timeout counter cleared -> DISCARD.
  - 0x03 SET_EN: 1 data byte. dds_en <= byte[0] -> DISCARD.
  - Any other opcode: err <= 1 -> DISCARD.
- Extra bytes after a completed command are ignored, with no error.
- Commit FSM states:
  - C_IDLE: pending = 0.
  - C_PEND: pending = 1; counter increments each cycle.
  - C_PEND -> C_IDLE when phase_wrap = 1 OR counter == COMMIT_TIMEOUT-1. On that transition, in the same cycle: fword_out <= shadow, fword_load = 1 for one cycle.
- Latency: phase_wrap at cycle n -> fword_out updated and fword_load high at cycle n+1.
- Simultaneous events:
  - COMMIT received while in C_PEND: re-arm; counter restarts; still a single load.
  - Shadow update in the same cycle as an apply: the apply uses the pre-update shadow.
  - COMMIT opcode and phase_wrap in the same cycle: pending set; the load waits for the next phase_wrap.
- tx_byte = {pending, dds_en, err, 1'b0, state[1:0], 2'b00}, registered, updated every cycle.
- err clears only on reset, or on opcode 0x04 CLR_ERR (no data).
- Reset mid-frame or mid-pending: everything returns to reset values immediately; no fword_load pulse.
- Counter width: TIMEOUT_W bits. COMMIT_TIMEOUT must be >= 1; the counter never wraps in C_PEND.

Optional Feature:
- Macro: FWORD_CRC_EN.
- Defined: WRITE_FWORD carries a 5th byte = XOR of the 4 data bytes.
  - Match: shadow updated.
  - Mismatch: shadow unchanged, err <= 1.
  - cs_n high before the 5th byte: write dropped.
- Undefined: 4-byte WRITE_FWORD; no checksum logic is synthesised.

Test Plan:
- Reset state: assert rst low mid-operation -> fword_out = RESET_FWORD, dds_en = 0, pending = 0, err = 0, tx_byte = 8'h00, no fword_load.
- Glitch-free commit: frame 01 12 34 56 78, then frame 02; phase_wrap 20 cycles later -> pending high until then; fword_out = 32'h12345678 and fword_load one cycle after phase_wrap.
- Timeout: COMMIT with no phase_wrap, COMMIT_TIMEOUT = 100 -> load after exactly 100 cycles in C_PEND.
- Aborted write: frame 01 AA BB, then cs_n high -> shadow unchanged; a subsequent COMMIT loads the old value.
- Bad opcode and CLR_ERR: opcode 0x7F -> err = 1, tx_byte[5] = 1; frame 04 -> err = 0.
- Enable: frame 03 01 -> dds_en = 1; frame 03 00 -> dds_en = 0. With FWORD_CRC_EN: 01 12 34 56 78 08 accepted; 01 12 34 56 78 00 -> err = 1, shadow unchanged.

Source files
------------

// File: rtl/dds_fword_ctrl.sv
// SPI command decoder that stages a DDS frequency word and commits it on a phase wrap
// (or a timeout). Optional FWORD_CRC_EN adds an XOR check byte to WRITE_FWORD frames.
module dds_fword_ctrl #(
    parameter logic [31:0]          RESET_FWORD    = 32'd0,
    parameter int                   TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0] COMMIT_TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    input  logic        phase_wrap,
    output logic [31:0] fword_out,
    output logic        fword_load,
    output logic        dds_en,
    output logic        pending,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPCODE  = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } frame_state_t;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_PEND = 1'b1
    } commit_state_t;

    localparam logic [7:0] OP_WRITE_FWORD = 8'h01;
    localparam logic [7:0] OP_COMMIT      = 8'h02;
    localparam logic [7:0] OP_SET_EN      = 8'h03;
    localparam logic [7:0] OP_CLR_ERR     = 8'h04;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = COMMIT_TIMEOUT - TIMEOUT_W'(1);

`ifdef FWORD_CRC_EN
    localparam logic [2:0] WR_LAST = 3'd4;
`else
    localparam logic [2:0] WR_LAST = 3'd3;
`endif

    frame_state_t         state;
    commit_state_t        cstate;
    logic                 cs_meta;
    logic                 cs_sync;
    logic                 cs_prev;
    logic                 cs_fall;
    logic                 op_write;
    logic [2:0]           byte_cnt;
    logic [31:0]          assembly;
    logic [31:0]          shadow;
    logic                 shadow_wr;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 commit_cmd;
    logic                 apply;

    // Synchronisers idle high so a frame already open at reset release still shows a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_meta <= 1'b1;
            cs_sync <= 1'b1;
            cs_prev <= 1'b1;
        end else begin
            cs_meta <= cs_n;
            cs_sync <= cs_meta;
            cs_prev <= cs_sync;
        end
    end

    assign cs_fall = cs_prev & ~cs_sync;

    assign commit_cmd = ~cs_sync && (state == OPCODE) && rx_valid && (rx_byte == OP_COMMIT);

    // A COMMIT decoded in the same cycle as a wrap re-arms instead of applying.
    assign apply = (cstate == C_PEND) && !commit_cmd &&
                   (phase_wrap || (tmo_cnt == TIMEOUT_LAST));

`ifdef FWORD_CRC_EN
    logic [7:0] crc;
    assign crc = assembly[31:24] ^ assembly[23:16] ^ assembly[15:8] ^ assembly[7:0];
`endif

    // Frame decoder; shadow is written the cycle after the last accepted write byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op_write  <= 1'b0;
            byte_cnt  <= 3'd0;
            assembly  <= 32'd0;
            shadow    <= RESET_FWORD;
            shadow_wr <= 1'b0;
            dds_en    <= 1'b0;
            err       <= 1'b0;
        end else begin
            shadow_wr <= 1'b0;
            if (shadow_wr) begin
                shadow <= assembly;
            end
            if (cs_sync) begin
                state    <= IDLE;
                byte_cnt <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state <= OPCODE;
                        end
                    end
                    OPCODE: begin
                        if (rx_valid) begin
                            byte_cnt <= 3'd0;
                            case (rx_byte)
                                OP_WRITE_FWORD: begin
                                    op_write <= 1'b1;
                                    state    <= DATA;
                                end
                                OP_COMMIT: begin
                                    state <= DISCARD;
                                end
                                OP_SET_EN: begin
                                    op_write <= 1'b0;
                                    state    <= DATA;
                                end
                                OP_CLR_ERR: begin
                                    err   <= 1'b0;
                                    state <= DISCARD;
                                end
                                default: begin
                                    err   <= 1'b1;
                                    state <= DISCARD;
                                end
                            endcase
                        end
                    end
                    DATA: begin
                        if (rx_valid) begin
                            if (!op_write) begin
                                dds_en <= rx_byte[0];
                                state  <= DISCARD;
                            end else begin
                                byte_cnt <= byte_cnt + 3'd1;
`ifdef FWORD_CRC_EN
                                if (byte_cnt == WR_LAST) begin
                                    if (rx_byte == crc) begin
                                        shadow_wr <= 1'b1;
                                    end else begin
                                        err <= 1'b1;
                                    end
                                    state <= DISCARD;
                                end else begin
                                    assembly <= {assembly[23:0], rx_byte};
                                end
`else
                                assembly <= {assembly[23:0], rx_byte};
                                if (byte_cnt == WR_LAST) begin
                                    shadow_wr <= 1'b1;
                                    state     <= DISCARD;
                                end
`endif
                            end
                        end
                    end
                    DISCARD: begin
                        state <= DISCARD;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Commit FSM: the counter only advances in C_PEND and stops at TIMEOUT_LAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cstate     <= C_IDLE;
            tmo_cnt    <= '0;
            fword_out  <= RESET_FWORD;
            fword_load <= 1'b0;
        end else begin
            fword_load <= 1'b0;
            if (commit_cmd) begin
                cstate  <= C_PEND;
                tmo_cnt <= '0;
            end else if (apply) begin
                cstate     <= C_IDLE;
                tmo_cnt    <= '0;
                fword_out  <= shadow;
                fword_load <= 1'b1;
            end else if (cstate == C_PEND) begin
                tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
            end
        end
    end

    assign pending = (cstate == C_PEND);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_byte <= 8'h00;
        end else begin
            tx_byte <= {pending, dds_en, err, 1'b0, state, 2'b00};
        end
    end

endmodule
